// File: rtl/pipe_id_operand.sv
// ID-stage operand supply: register file with write-through bypass, EX/MEM forwarding
// selection, load-use stall detection and a saturating stall-cycle counter.
module pipe_id_operand #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [4:0]       rs,
    input  logic [4:0]       rt,
    input  logic             urs,
    input  logic             urt,
    input  logic [4:0]       ern,
    input  logic             ewreg,
    input  logic             em2reg,
    input  logic [31:0]      ealu,
    input  logic [4:0]       mrn,
    input  logic             mwreg,
    input  logic             mm2reg,
    input  logic [31:0]      malu,
    input  logic [31:0]      mmo,
    input  logic [4:0]       wrn,
    input  logic             wwreg,
    input  logic [31:0]      wdi,
    output logic [31:0]      da,
    output logic [31:0]      db,
    output logic [1:0]       fwda,
    output logic [1:0]       fwdb,
    output logic             stall,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [1:0] FwdRf   = 2'd0;
    localparam logic [1:0] FwdEx   = 2'd1;
    localparam logic [1:0] FwdMAlu = 2'd2;
    localparam logic [1:0] FwdMMo  = 2'd3;

    // Entry 0 is cleared on reset and never written, so it stays zero.
    logic [31:0] regs_q [32];

    logic [31:0]      rf_a, rf_b;
    logic             ex_hit_a, ex_hit_b;
    logic             mem_hit_a, mem_hit_b;
    logic             ex_load;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wwreg && (wrn != 5'd0)) begin
            regs_q[wrn] <= wdi;
        end
    end

    // Write-through bypass lets WB and ID share a cycle without a stall.
    always_comb begin
        rf_a = '0;
        rf_b = '0;
        if (rs != 5'd0) begin
            rf_a = (wwreg && (wrn == rs)) ? wdi : regs_q[rs];
        end
        if (rt != 5'd0) begin
            rf_b = (wwreg && (wrn == rt)) ? wdi : regs_q[rt];
        end
    end

    // A load in EX has no data yet, so it never forwards from EX.
    assign ex_hit_a  = ewreg && !em2reg && (ern != 5'd0) && (ern == rs);
    assign ex_hit_b  = ewreg && !em2reg && (ern != 5'd0) && (ern == rt);
    assign mem_hit_a = mwreg && (mrn != 5'd0) && (mrn == rs);
    assign mem_hit_b = mwreg && (mrn != 5'd0) && (mrn == rt);

    always_comb begin
        fwda = FwdRf;
        if (ex_hit_a) begin
            fwda = FwdEx;
        end else if (mem_hit_a) begin
            fwda = mm2reg ? FwdMMo : FwdMAlu;
        end

        fwdb = FwdRf;
        if (ex_hit_b) begin
            fwdb = FwdEx;
        end else if (mem_hit_b) begin
            fwdb = mm2reg ? FwdMMo : FwdMAlu;
        end
    end

    always_comb begin
        unique case (fwda)
            FwdEx:   da = ealu;
            FwdMAlu: da = malu;
            FwdMMo:  da = mmo;
            default: da = rf_a;
        endcase
        unique case (fwdb)
            FwdEx:   db = ealu;
            FwdMAlu: db = malu;
            FwdMMo:  db = mmo;
            default: db = rf_b;
        endcase
    end

    assign ex_load = ewreg && em2reg && (ern != 5'd0);
    assign stall   = ex_load && ((urs && (ern == rs)) || (urt && (ern == rt)));

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: doc/pipe_id_operand.md
PIPE_ID_OPERAND -- requirements
Module: pipe_id_operand

Interface
REQ-001 Parameter CNT_W, default 32, width of the load-use stall counter.
REQ-002 clock  in  1  rising-edge clock for all state.
REQ-003 resetn  in  1  synchronous, active-low reset; one clock, synchronous active-low reset, sampled on rising clock edge.
REQ-004 rs, rt  in  5 each  ID-stage source register numbers.
REQ-005 urs, urt  in  1 each  instruction in ID actually reads rs / rt.
REQ-006 ern  in  5  EX destination register (already 31 for jal).
REQ-007 ewreg, em2reg  in  1 each  EX writes register / EX is a load.
REQ-008 ealu  in  32  EX result (PC+8 for jal).
REQ-009 mrn  in  5; mwreg, mm2reg  in  1 each  MEM destination, write enable, load flag.
REQ-010 malu, mmo  in  32 each  MEM ALU result / MEM load data.
REQ-011 wrn  in  5; wwreg  in  1; wdi  in  32  WB write port.
REQ-012 da, db  out  32 each  forwarded operands for rs / rt.
REQ-013 fwda, fwdb  out  2 each  source select: 0 regfile, 1 EX ealu, 2 MEM malu, 3 MEM mmo.
REQ-014 stall  out  1  load-use hazard; freeze PC and IF/ID, bubble ID/EX.
REQ-015 stall_cnt  out  CNT_W  number of stall cycles since reset.

Function
REQ-016 Register file SHALL hold 31 writable 32-bit registers r1..r31; r0 SHALL read 0 always and ignore writes.
REQ-017 On rising edge with resetn=1, wwreg=1, wrn!=0: reg[wrn] <= wdi.
REQ-018 Reads SHALL be combinational; same-cycle read of reg being written (wwreg, wrn==rs/rt, wrn!=0) SHALL return wdi (internal bypass, fwd code 0).
REQ-019 fwda priority: EX hit (ewreg & ~em2reg & ern!=0 & ern==rs) -> 1; else MEM hit (mwreg & mrn!=0 & mrn==rs) -> 2 if ~mm2reg, 3 if mm2reg; else 0.
REQ-020 fwdb identical to fwda using rt.
REQ-021 da/db SHALL equal the source selected by fwda/fwdb; all paths combinational, zero latency.
REQ-022 Forwarding SHALL be computed regardless of urs/urt; urs/urt gate only stall.
REQ-023 stall = ewreg & em2reg & ern!=0 & ((urs & ern==rs) | (urt & ern==rt)); combinational.
REQ-024 While stall=1, fwd codes SHALL still be driven (don't-care to consumer) but SHALL NOT select 1 for a load in EX.
REQ-025 stall_cnt SHALL increment by 1 each rising edge where stall=1 and resetn=1; SHALL saturate at all-ones, no wrap.
REQ-026 Register 0 target in EX/MEM/WB SHALL never forward or stall.
REQ-027 Simultaneous EX and MEM hits on same register: EX wins (youngest value).
REQ-028 Simultaneous MEM and WB hits: MEM wins; WB served by internal bypass only when no EX/MEM hit.

Reset
REQ-029 resetn=0 at rising edge: all r1..r31 <= 0, stall_cnt <= 0; WB write in that cycle SHALL be discarded.
REQ-030 Combinational outputs (da, db, fwd*, stall) SHALL follow inputs during reset; reads return 0 after the reset edge.
REQ-031 Reset asserted mid-stall SHALL clear stall_cnt; stall itself still reflects inputs.

Verification
REQ-032 Reset, then wwreg=1 wrn=5 wdi=0x1234 one edge; rs=5 no hazards -> da=0x1234, fwda=0.
REQ-033 wrn=5 wdi=0xAAAA wwreg=1, rs=5 same cycle, no EX/MEM hit -> da=0xAAAA before edge.
REQ-034 ern=8 ewreg=1 em2reg=0 ealu=0x10, mrn=8 mwreg=1 malu=0x20, rs=8 -> fwda=1, da=0x10; drop ewreg -> fwda=2, da=0x20; set mm2reg=1 mmo=0x30 -> fwda=3, da=0x30.
REQ-035 ern=9 ewreg=1 em2reg=1, rt=9 urt=1 for 3 edges -> stall=1, stall_cnt=3; urt=0 -> stall=0, count holds.
REQ-036 ern=0 ewreg=1 em2reg=1, rs=0 urs=1 -> stall=0, fwda=0, da=0; wrn=0 wdi=0xFFFF write -> r0 still 0.
REQ-037 ern=31 ewreg=1 ealu=PC+8=0x408 (jal), rs=31 -> fwda=1, da=0x408.
